// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    S_CPU   = 2'd0,
    S_EXT   = 2'd1,
    S_YIELD = 2'd2
  } arb_state_t;

  localparam logic [31:0] DATA_BASE_DEF  = 32'h1001_0000;
  localparam int          DMEM_DEPTH     = 2048;
  localparam int          DMEM_ADDR_W    = $clog2(DMEM_DEPTH);
  localparam int          STARVE_MAX_DEF = 8;
  localparam int          BURST_MAX_DEF  = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU data port, external DMA/loader port and dmem strobes bundled as one bus.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W
);
  logic              cpu_r;
  logic              cpu_w;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [31:0]       ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [31:0]       ext_rdata;
  logic              dm_r;
  logic              dm_w;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic              addr_err;

  // slave: the arbiter; master: the surrounding CPU/ext/dmem environment
  modport slave (
    input  cpu_r, cpu_w, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  dm_rdata,
    output cpu_rdata, cpu_stall,
    output ext_gnt, ext_rvalid, ext_rdata,
    output dm_r, dm_w, dm_addr, dm_wdata,
    output addr_err
  );

  modport master (
    output cpu_r, cpu_w, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output dm_rdata,
    input  cpu_rdata, cpu_stall,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  dm_r, dm_w, dm_addr, dm_wdata,
    input  addr_err
  );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Up-counter that saturates at MAX; clear wins over increment.
module arb_sat_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between the CPU data port (priority) and an ext port
// that gets bounded bursts and a starvation guarantee.
//
//   state   | meaning
//   S_CPU   | CPU owns dmem; ext admitted when CPU idle or starve_cnt at max
//   S_EXT   | ext owns dmem, one beat per requesting cycle; CPU stalled
//   S_YIELD | one forced CPU-only cycle after a full burst
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          ADDR_W     = DMEM_ADDR_W,
  parameter logic [31:0] DATA_BASE  = DATA_BASE_DEF,
  parameter int          STARVE_MAX = STARVE_MAX_DEF,
  parameter int          BURST_MAX  = BURST_MAX_DEF
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam int          SW        = $clog2(STARVE_MAX + 1);
  localparam int          BW        = $clog2(BURST_MAX + 1);
  localparam logic [32:0] WIN_BYTES = 33'd4 << ADDR_W;

  arb_state_t    state, state_nxt;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] beat_cnt;
  logic [31:0]   cpu_off;
  logic          cpu_act, addr_ok, ext_beat, ext_rd_beat, starve_full, last_beat;

  assign cpu_act     = bus.cpu_r | bus.cpu_w;
  assign cpu_off     = bus.cpu_addr - DATA_BASE;
  assign addr_ok     = (bus.cpu_addr >= DATA_BASE) && ({1'b0, cpu_off} < WIN_BYTES)
                       && (bus.cpu_addr[1:0] == 2'b00);
  assign starve_full = (starve_cnt == SW'(STARVE_MAX));
  assign last_beat   = (beat_cnt == BW'(BURST_MAX - 1));
  assign ext_beat    = (state == S_EXT) && bus.ext_req;
  assign ext_rd_beat = ext_beat && !bus.ext_we;

  arb_sat_counter #(.MAX(STARVE_MAX), .W(SW)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc ((state == S_CPU) && bus.ext_req && cpu_act),
    .clr ((state == S_EXT) || !bus.ext_req),
    .cnt (starve_cnt)
  );

  arb_sat_counter #(.MAX(BURST_MAX), .W(BW)) u_beat (
    .clk (clk),
    .rst (rst),
    .inc (ext_beat),
    .clr ((state != S_EXT) && (state_nxt == S_EXT)),
    .cnt (beat_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_CPU;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CPU:   if (bus.ext_req && (!cpu_act || starve_full)) state_nxt = S_EXT;
      S_EXT: begin
        if (!bus.ext_req)   state_nxt = S_CPU;
        else if (last_beat) state_nxt = S_YIELD;
      end
      S_YIELD: state_nxt = S_CPU;
      default: state_nxt = S_CPU;
    endcase
  end

  always_comb begin
    bus.ext_gnt   = 1'b0;
    bus.cpu_stall = 1'b0;
    bus.dm_r      = bus.cpu_r & addr_ok;
    bus.dm_w      = bus.cpu_w & addr_ok;
    bus.dm_addr   = cpu_off[ADDR_W+1:2];
    bus.dm_wdata  = bus.cpu_wdata;
    if (state == S_EXT) begin
      bus.ext_gnt   = bus.ext_req;
      bus.cpu_stall = cpu_act;
      bus.dm_r      = bus.ext_req & ~bus.ext_we;
      bus.dm_w      = bus.ext_req & bus.ext_we;
      bus.dm_addr   = bus.ext_addr;
      bus.dm_wdata  = bus.ext_wdata;
    end
  end

  // Bad CPU addresses read as zero so stray loads never see aliased words
  assign bus.cpu_rdata = addr_ok ? bus.dm_rdata : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ext_rvalid <= 1'b0;
      bus.ext_rdata  <= '0;
      bus.addr_err   <= 1'b0;
    end else begin
      bus.ext_rvalid <= ext_rd_beat;
      if (ext_rd_beat) bus.ext_rdata <= bus.dm_rdata;
      if (cpu_act && !addr_ok && (state != S_EXT)) bus.addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int          AW     = 11;
  localparam int          DEPTH  = 2048;
  localparam logic [31:0] BASE   = 32'h1001_0000;
  localparam int          STARVE = 8;
  localparam int          BURST  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW)) bus ();

  dmem_arbiter #(
    .ADDR_W(AW), .DATA_BASE(BASE), .STARVE_MAX(STARVE), .BURST_MAX(BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // dmem: combinational read, write on clock edge
  logic [31:0] mem [DEPTH];
  assign bus.dm_rdata = mem[bus.dm_addr];
  always @(posedge clk) if (bus.dm_w) mem[bus.dm_addr] = bus.dm_wdata;

  // reference model
  logic [31:0] ref_mem [DEPTH];
  bit          m_ext, m_yield, m_rvalid, m_err;
  int          m_denied, m_beats;
  logic [31:0] m_rdata;

  int          n_vec, n_err;
  logic        obs_gnt, obs_stall, obs_dm_w, obs_dm_r, obs_rvalid;
  logic [31:0] obs_rdata, obs_cpu_rdata;
  logic [AW-1:0] obs_dm_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit win_ok(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH)) && (a % 4 == 0);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'(((a - BASE) / 4) % DEPTH);
  endfunction

  // Called at posedge+1 with inputs set; checks at negedge, returns at next posedge+1.
  task automatic tick();
    bit cpu_act, grant, perf, bad;
    int idx;
    @(negedge clk);
    obs_gnt = bus.ext_gnt;       obs_stall = bus.cpu_stall;
    obs_dm_w = bus.dm_w;         obs_dm_r = bus.dm_r;
    obs_dm_addr = bus.dm_addr;   obs_cpu_rdata = bus.cpu_rdata;
    obs_rvalid = bus.ext_rvalid; obs_rdata = bus.ext_rdata;
    cpu_act = bus.cpu_r | bus.cpu_w;
    grant   = m_ext && bus.ext_req;
    perf    = !m_ext && cpu_act && win_ok(bus.cpu_addr);
    bad     = !m_ext && cpu_act && !win_ok(bus.cpu_addr);
    idx     = word_of(bus.cpu_addr);
    chk("ext_gnt", 32'(obs_gnt), 32'(grant));
    chk("cpu_stall", 32'(obs_stall), 32'(m_ext && cpu_act));
    chk("dm_w", 32'(obs_dm_w), 32'((grant && bus.ext_we) || (perf && bus.cpu_w)));
    chk("dm_r", 32'(obs_dm_r), 32'((grant && !bus.ext_we) || (perf && bus.cpu_r)));
    if (grant)     chk("dm_addr_ext", 32'(obs_dm_addr), 32'(bus.ext_addr));
    else if (perf) chk("dm_addr_cpu", 32'(obs_dm_addr), 32'(idx));
    if (!m_ext && bus.cpu_r) chk("cpu_rdata", obs_cpu_rdata, perf ? ref_mem[idx] : 32'h0);
    chk("ext_rvalid", 32'(obs_rvalid), 32'(m_rvalid));
    chk("ext_rdata", obs_rdata, m_rdata);
    chk("addr_err", 32'(bus.addr_err), 32'(m_err));

    m_rvalid = grant && !bus.ext_we;
    if (m_rvalid) m_rdata = ref_mem[bus.ext_addr];
    if (grant && bus.ext_we) ref_mem[bus.ext_addr] = bus.ext_wdata;
    if (perf && bus.cpu_w) ref_mem[idx] = bus.cpu_wdata;
    if (bad) m_err = 1'b1;

    if (m_ext) begin
      m_denied = 0;
      if (!bus.ext_req) m_ext = 1'b0;
      else begin
        m_beats++;
        if (m_beats == BURST) begin m_ext = 1'b0; m_yield = 1'b1; end
      end
    end else if (m_yield) begin
      m_yield = 1'b0;
      if (!bus.ext_req) m_denied = 0;
    end else begin
      if (bus.ext_req && (!cpu_act || m_denied == STARVE)) begin m_ext = 1'b1; m_beats = 0; end
      if (!bus.ext_req) m_denied = 0;
      else if (cpu_act && m_denied < STARVE) m_denied++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_r = 1'b0; bus.cpu_w = 1'b0; bus.cpu_addr = BASE; bus.cpu_wdata = '0;
    bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;
  endtask

  task automatic model_reset();
    m_ext = 1'b0; m_yield = 1'b0; m_rvalid = 1'b0; m_err = 1'b0;
    m_denied = 0; m_beats = 0; m_rdata = '0; obs_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int nxt, ncyc, nrv, lat, nst, ngt;
    bit stall_seen;
    logic [15:0] pat;
    n_vec = 0; n_err = 0;
    for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    do_reset();
    chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'h0);
    chk("rst_ext_gnt", 32'(bus.ext_gnt), 32'h0);
    chk("rst_ext_rvalid", 32'(bus.ext_rvalid), 32'h0);
    chk("rst_ext_rdata", bus.ext_rdata, 32'h0);
    chk("rst_addr_err", 32'(bus.addr_err), 32'h0);

    // CPU only write then read
    bus.cpu_w = 1'b1; bus.cpu_addr = 32'h1001_0008; bus.cpu_wdata = 32'hDEAD_BEEF;
    tick(); stall_seen = obs_stall;
    chk("cpu_wr_dm_addr", 32'(obs_dm_addr), 32'd2);
    chk("cpu_wr_dm_w", 32'(obs_dm_w), 32'd1);
    bus.cpu_w = 1'b0; bus.cpu_r = 1'b1;
    tick(); stall_seen |= obs_stall;
    chk("cpu_rd_dm_addr", 32'(obs_dm_addr), 32'd2);
    chk("cpu_rd_data", obs_cpu_rdata, 32'hDEAD_BEEF);
    chk("cpu_no_stall", 32'(stall_seen), 32'd0);
    bus.cpu_r = 1'b0;

    // ext burst write words 0..5, CPU idle
    bus.ext_req = 1'b1; bus.ext_we = 1'b1; nxt = 0; ncyc = 0; pat = '0;
    while (nxt < 6 && ncyc < 20) begin
      bus.ext_addr = AW'(nxt); bus.ext_wdata = 32'hA5A5_0000 + 32'(nxt);
      tick(); ncyc++;
      pat = {pat[14:0], obs_gnt};
      if (obs_gnt) nxt++;
    end
    bus.ext_req = 1'b0;
    chk("burst_pattern", 32'(pat), 32'b0_1111_0011);
    chk("burst_cycles", 32'(ncyc), 32'd9);

    // ext readback words 0..5
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; nxt = 0; nrv = 0; ncyc = 0;
    while ((nxt < 6 || nrv < 6) && ncyc < 25) begin
      if (nxt >= 6) bus.ext_req = 1'b0;
      bus.ext_addr = AW'(nxt < 6 ? nxt : 0);
      tick(); ncyc++;
      if (obs_rvalid) begin
        chk("readback_data", obs_rdata, 32'hA5A5_0000 + 32'(nrv));
        nrv++;
      end
      if (obs_gnt) nxt++;
    end
    bus.ext_req = 1'b0;
    chk("readback_count", 32'(nrv), 32'd6);

    // starvation: CPU reads every cycle while ext requests continuously
    bus.cpu_r = 1'b1; bus.cpu_addr = BASE + 32'd4;
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = AW'(1);
    lat = -1; nst = 0; ngt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (obs_gnt && lat < 0) lat = c;
      nst += int'(obs_stall);
      ngt += int'(obs_gnt);
    end
    idle_inputs();
    chk("starve_latency", 32'(lat), 32'd9);
    chk("starve_beats", 32'(ngt), 32'd8);
    chk("starve_stalls", 32'(nst), 32'd8);

    // address errors: out of window and misaligned
    bus.cpu_w = 1'b1; bus.cpu_addr = 32'h1001_2000; bus.cpu_wdata = 32'h0BAD_0BAD;
    tick();
    chk("aerr_oow_dm_w", 32'(obs_dm_w), 32'd0);
    bus.cpu_addr = 32'h1001_0002;
    tick();
    chk("aerr_mis_dm_w", 32'(obs_dm_w), 32'd0);
    bus.cpu_w = 1'b0;
    repeat (3) tick();
    chk("aerr_sticky", 32'(bus.addr_err), 32'd1);
    chk("aerr_mem0", mem[0], 32'hA5A5_0000);

    // reset during the second ext read beat
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = AW'(3);
    tick(); tick();
    chk("mid_rvalid_before", 32'(bus.ext_rvalid), 32'd1);
    chk("mid_gnt_before", 32'(bus.ext_gnt), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rvalid_rst", 32'(bus.ext_rvalid), 32'd0);
    chk("mid_gnt_rst", 32'(bus.ext_gnt), 32'd0);
    chk("mid_stall_rst", 32'(bus.cpu_stall), 32'd0);
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ngt = 0;
    repeat (4) begin tick(); ngt += int'(obs_gnt); end
    chk("mid_no_gnt_after", 32'(ngt), 32'd0);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!obs_stall) begin
        int op, r;
        op = int'($urandom_range(0, 3));
        bus.cpu_r = (op == 1) || (op == 3);
        bus.cpu_w = (op == 2);
        bus.cpu_wdata = $urandom;
        r = int'($urandom_range(0, 63));
        if (r == 0)      bus.cpu_addr = BASE + 32'h2000 + 32'(4 * $urandom_range(0, 7));
        else if (r == 1) bus.cpu_addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'd1;
        else if (r == 2) bus.cpu_addr = BASE - 32'd4;
        else             bus.cpu_addr = BASE + 32'(4 * $urandom_range(0, 15));
      end
      bus.ext_req   = ($urandom_range(0, 3) != 0);
      bus.ext_we    = $urandom_range(0, 1) == 1;
      bus.ext_addr  = AW'($urandom_range(0, 15));
      bus.ext_wdata = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
